// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO registers for the MIPS EX stage.
// MULT/MULTU/DIV/DIVU take WIDTH+1 cycles; MTHI/MTLO write HI/LO in a single cycle.
module mult_div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             CLOCK,
   input  logic             RESET,
   input  logic             Start,
   input  logic [2:0]       Op,
   input  logic [WIDTH-1:0] OpA,
   input  logic [WIDTH-1:0] OpB,
   input  logic             Flush,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   localparam logic [2:0] OP_MULTU = 3'd0;
   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_DIVU  = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   state_t             state_reg;
   logic [CNT_W-1:0]   count_reg;
   logic [WIDTH-1:0]   opb_mag_reg;
   logic [WIDTH-1:0]   acc_hi_reg;
   logic [WIDTH-1:0]   acc_lo_reg;
   logic               is_div_reg;
   logic               neg_res_reg;
   logic               neg_rem_reg;
   logic               div_zero_reg;

   logic               is_signed;
   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH+1:0]   div_diff;
   logic               div_borrow;
   logic [2*WIDTH-1:0] prod_mag;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   always_comb begin
      is_signed = Op[0];
      a_neg     = is_signed & OpA[WIDTH-1];
      b_neg     = is_signed & OpB[WIDTH-1];
      a_mag     = a_neg ? (~OpA + 1'b1) : OpA;
      b_mag     = b_neg ? (~OpB + 1'b1) : OpB;
   end

   // Multiply and divide share the accumulator: acc_lo starts as |OpA| in both cases.
   always_comb begin
      mul_sum    = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, opb_mag_reg} : {(WIDTH+1){1'b0}});
      div_diff   = {1'b0, acc_hi_reg, acc_lo_reg[WIDTH-1]} - {2'b00, opb_mag_reg};
      div_borrow = div_diff[WIDTH+1];
   end

   always_comb begin
      prod_mag = {acc_hi_reg, acc_lo_reg};
      prod_fix = neg_res_reg ? (~prod_mag + 1'b1) : prod_mag;
      if (div_zero_reg)
         quo_fix = {WIDTH{1'b1}};
      else
         quo_fix = neg_res_reg ? (~acc_lo_reg + 1'b1) : acc_lo_reg;
      rem_fix = neg_rem_reg ? (~acc_hi_reg + 1'b1) : acc_hi_reg;
   end

   assign Busy = (state_reg != IDLE);

   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         state_reg    <= IDLE;
         count_reg    <= '0;
         opb_mag_reg  <= '0;
         acc_hi_reg   <= '0;
         acc_lo_reg   <= '0;
         is_div_reg   <= 1'b0;
         neg_res_reg  <= 1'b0;
         neg_rem_reg  <= 1'b0;
         div_zero_reg <= 1'b0;
         HI           <= '0;
         LO           <= '0;
         Done         <= 1'b0;
      end else begin
         Done <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (Start && !Flush) begin
                  case (Op)
                     OP_MULTU, OP_MULT, OP_DIVU, OP_DIV: begin
                        opb_mag_reg  <= b_mag;
                        acc_hi_reg   <= '0;
                        acc_lo_reg   <= a_mag;
                        is_div_reg   <= Op[1];
                        neg_res_reg  <= a_neg ^ b_neg;
                        neg_rem_reg  <= a_neg;
                        div_zero_reg <= (OpB == '0);
                        count_reg    <= CNT_W'(WIDTH - 1);
                        state_reg    <= CALC;
                     end
                     OP_MTHI: HI <= OpA;
                     OP_MTLO: LO <= OpA;
                     default: ;
                  endcase
               end
            end
            CALC: begin
               if (Flush) begin
                  state_reg <= IDLE;
               end else begin
                  if (is_div_reg) begin
                     acc_lo_reg <= {acc_lo_reg[WIDTH-2:0], ~div_borrow};
                     acc_hi_reg <= div_borrow ? {acc_hi_reg[WIDTH-2:0], acc_lo_reg[WIDTH-1]}
                                              : div_diff[WIDTH-1:0];
                  end else begin
                     acc_hi_reg <= mul_sum[WIDTH:1];
                     acc_lo_reg <= {mul_sum[0], acc_lo_reg[WIDTH-1:1]};
                  end
                  count_reg <= count_reg - 1'b1;
                  if (count_reg == '0)
                     state_reg <= FIX;
               end
            end
            FIX: begin
               // A flush arriving with the final step still discards the result.
               if (!Flush) begin
                  if (is_div_reg) begin
                     HI <= rem_fix;
                     LO <= quo_fix;
                  end else begin
                     HI <= prod_fix[2*WIDTH-1:WIDTH];
                     LO <= prod_fix[WIDTH-1:0];
                  end
                  Done <= 1'b1;
               end
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule
